regfile_debug_arbiter: RTL and testbench

- Shares the processor's register file (2 read ports, 1 write port) between the pipeline and an external debug/loader host.
- In RUN, all ports pass straight through to the pipeline.
- On a host halt request, the block holds the processor in reset, drains in-flight writebacks, then gives the host exclusive write access and read port 1 for preloading and inspecting registers.
- Sits at the top level between the processor's register-file ports and the register file instance.

---
 rtl/regfile_debug_arbiter.sv | 115 +++++++++++
 tb/tb_regfile_debug_arbiter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_debug_arbiter.sv
// Shares the register file between the pipeline and a debug/loader host.
// The host halts the core, waits out in-flight writebacks, then owns the write port and read port 1.
module regfile_debug_arbiter #(
  parameter int ADDR_WIDTH   = 6,
  parameter int DATA_WIDTH   = 32,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] cpu_read_address_1,
  input  logic [ADDR_WIDTH-1:0] cpu_read_address_2,
  output logic [DATA_WIDTH-1:0] cpu_read_value_1,
  output logic [DATA_WIDTH-1:0] cpu_read_value_2,
  input  logic [ADDR_WIDTH-1:0] cpu_write_address,
  input  logic [DATA_WIDTH-1:0] cpu_write_value,
  input  logic                  cpu_write_enable,
  output logic                  cpu_hold,
  output logic [ADDR_WIDTH-1:0] rf_read_address_1,
  output logic [ADDR_WIDTH-1:0] rf_read_address_2,
  input  logic [DATA_WIDTH-1:0] rf_read_value_1,
  input  logic [DATA_WIDTH-1:0] rf_read_value_2,
  output logic [ADDR_WIDTH-1:0] rf_write_address,
  output logic [DATA_WIDTH-1:0] rf_write_value,
  output logic                  rf_write_enable,
  input  logic                  dbg_halt,
  output logic                  dbg_halted,
  input  logic                  dbg_valid,
  output logic                  dbg_ready,
  input  logic                  dbg_write,
  input  logic [ADDR_WIDTH-1:0] dbg_address,
  input  logic [DATA_WIDTH-1:0] dbg_wdata,
  output logic                  dbg_rvalid,
  output logic [DATA_WIDTH-1:0] dbg_rdata
);

  localparam int CW = 4;

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

  state_t        state, state_next;
  logic [CW-1:0] drain_count, drain_count_next;
  logic          accept, host_write, host_read;
  logic          address_in_range, write_allowed;

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= RUN;
      drain_count <= '0;
    end else begin
      state       <= state_next;
      drain_count <= drain_count_next;
    end
  end

  // Once started, a drain always runs to completion regardless of dbg_halt.
  always_comb begin
    state_next       = state;
    drain_count_next = drain_count;
    case (state)
      RUN: begin
        if (dbg_halt) begin
          state_next       = DRAIN;
          drain_count_next = CW'(DRAIN_CYCLES - 1);
        end
      end
      DRAIN: begin
        if (drain_count == '0) state_next = HALTED;
        else                   drain_count_next = drain_count - CW'(1);
      end
      HALTED: begin
        if (!dbg_halt) state_next = RUN;
      end
      default: state_next = RUN;
    endcase
  end

  assign cpu_hold   = (state != RUN);
  assign dbg_halted = (state == HALTED);
  assign dbg_ready  = (state == HALTED);

  assign accept           = dbg_valid && dbg_ready;
  assign host_write       = accept && dbg_write;
  assign host_read        = accept && !dbg_write;
  assign address_in_range = !dbg_address[ADDR_WIDTH-1];
  assign write_allowed    = address_in_range && (dbg_address != '0);

  assign cpu_read_value_1 = rf_read_value_1;
  assign cpu_read_value_2 = rf_read_value_2;

  // In HALTED the pipeline write is dropped: held-in-reset stages can emit junk writes.
  always_comb begin
    rf_read_address_1 = cpu_read_address_1;
    rf_read_address_2 = cpu_read_address_2;
    rf_write_address  = cpu_write_address;
    rf_write_value    = cpu_write_value;
    rf_write_enable   = cpu_write_enable;
    if (state == HALTED) begin
      rf_read_address_1 = dbg_address;
      rf_write_address  = dbg_address;
      rf_write_value    = dbg_wdata;
      rf_write_enable   = host_write && write_allowed;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      dbg_rvalid <= 1'b0;
      dbg_rdata  <= '0;
    end else begin
      dbg_rvalid <= host_read;
      if (host_read) dbg_rdata <= address_in_range ? rf_read_value_1 : '0;
    end
  end

endmodule

// File: tb/tb_regfile_debug_arbiter.sv
// Directed bench for regfile_debug_arbiter; the bench supplies a small register-file model
// seeded with 0xA000_0000 + index so untouched registers are recognisable.
module tb_regfile_debug_arbiter;

  localparam int AW = 6;
  localparam int DW = 32;

  logic          clock = 1'b0;
  logic          reset;
  logic [AW-1:0] cpu_read_address_1, cpu_read_address_2;
  logic [DW-1:0] cpu_read_value_1, cpu_read_value_2;
  logic [AW-1:0] cpu_write_address;
  logic [DW-1:0] cpu_write_value;
  logic          cpu_write_enable;
  logic          cpu_hold;
  logic [AW-1:0] rf_read_address_1, rf_read_address_2;
  logic [DW-1:0] rf_read_value_1, rf_read_value_2;
  logic [AW-1:0] rf_write_address;
  logic [DW-1:0] rf_write_value;
  logic          rf_write_enable;
  logic          dbg_halt, dbg_halted, dbg_valid, dbg_ready, dbg_write;
  logic [AW-1:0] dbg_address;
  logic [DW-1:0] dbg_wdata;
  logic          dbg_rvalid;
  logic [DW-1:0] dbg_rdata;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] regs [64];

  always #5 clock = ~clock;

  regfile_debug_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DRAIN_CYCLES(4)) dut (
    .clock(clock), .reset(reset),
    .cpu_read_address_1(cpu_read_address_1), .cpu_read_address_2(cpu_read_address_2),
    .cpu_read_value_1(cpu_read_value_1), .cpu_read_value_2(cpu_read_value_2),
    .cpu_write_address(cpu_write_address), .cpu_write_value(cpu_write_value),
    .cpu_write_enable(cpu_write_enable), .cpu_hold(cpu_hold),
    .rf_read_address_1(rf_read_address_1), .rf_read_address_2(rf_read_address_2),
    .rf_read_value_1(rf_read_value_1), .rf_read_value_2(rf_read_value_2),
    .rf_write_address(rf_write_address), .rf_write_value(rf_write_value),
    .rf_write_enable(rf_write_enable),
    .dbg_halt(dbg_halt), .dbg_halted(dbg_halted), .dbg_valid(dbg_valid),
    .dbg_ready(dbg_ready), .dbg_write(dbg_write), .dbg_address(dbg_address),
    .dbg_wdata(dbg_wdata), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata)
  );

  always @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 64; i++) regs[i] <= 32'hA000_0000 + DW'(i);
    end else if (rf_write_enable) begin
      regs[rf_write_address] <= rf_write_value;
    end
  end

  assign rf_read_value_1 = regs[rf_read_address_1];
  assign rf_read_value_2 = regs[rf_read_address_2];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [DW-1:0] observed,
                             input logic [DW-1:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        failures++;
        $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
  endtask

  task automatic applyStimulus(input logic valid, input logic write,
                               input logic [AW-1:0] address, input logic [DW-1:0] wdata);
    dbg_valid   = valid;
    dbg_write   = write;
    dbg_address = address;
    dbg_wdata   = wdata;
  endtask

  initial begin
    reset = 1'b1;
    cpu_read_address_1 = '0; cpu_read_address_2 = '0;
    cpu_write_address = '0; cpu_write_value = '0; cpu_write_enable = 1'b0;
    dbg_halt = 1'b0;
    applyStimulus(1'b0, 1'b0, '0, '0);
    tick(); tick();
    #1;
    checkOutput("reset_hold",   DW'(cpu_hold),   '0);
    checkOutput("reset_halted", DW'(dbg_halted), '0);
    checkOutput("reset_ready",  DW'(dbg_ready),  '0);
    checkOutput("reset_rvalid", DW'(dbg_rvalid), '0);
    checkOutput("reset_rdata",  dbg_rdata,       '0);
    reset = 1'b0;

    // RUN pass-through
    tick();
    cpu_write_enable = 1'b1; cpu_write_address = 6'd5; cpu_write_value = 32'h1234;
    cpu_read_address_1 = 6'd5; cpu_read_address_2 = 6'd2;
    #1;
    checkOutput("run_we",    DW'(rf_write_enable),   32'd1);
    checkOutput("run_waddr", DW'(rf_write_address),  32'd5);
    checkOutput("run_wval",  rf_write_value,         32'h1234);
    checkOutput("run_raddr1", DW'(rf_read_address_1), 32'd5);
    checkOutput("run_rval2", cpu_read_value_2,       32'hA000_0002);
    checkOutput("run_hold",  DW'(cpu_hold),          '0);
    tick();
    cpu_write_enable = 1'b0;
    #1;
    checkOutput("run_rval1_after_write", cpu_read_value_1, 32'h1234);

    // Halt request; host already presents a write that must wait for HALTED
    dbg_halt = 1'b1;
    applyStimulus(1'b1, 1'b1, 6'd9, 32'h55);
    #1;
    checkOutput("run_no_accept_we", DW'(rf_write_enable), '0);
    checkOutput("run_ready",        DW'(dbg_ready),       '0);
    tick();
    checkOutput("drain_hold",   DW'(cpu_hold),   32'd1);
    checkOutput("drain_halted", DW'(dbg_halted), '0);
    tick();
    cpu_write_enable = 1'b1; cpu_write_address = 6'd7; cpu_write_value = 32'h77;
    #1;
    checkOutput("drain_wb_we",    DW'(rf_write_enable),  32'd1);
    checkOutput("drain_wb_waddr", DW'(rf_write_address), 32'd7);
    checkOutput("drain_wb_wval",  rf_write_value,        32'h77);
    tick();
    cpu_write_enable = 1'b0;
    dbg_halt = 1'b0;
    tick();
    dbg_halt = 1'b1;
    #1;
    checkOutput("drain_last_halted", DW'(dbg_halted), '0);
    checkOutput("drain_last_rvalid", DW'(dbg_rvalid), '0);
    tick();
    cpu_read_address_2 = 6'd7;
    #1;
    checkOutput("halted_rises",     DW'(dbg_halted),       32'd1);
    checkOutput("halted_ready",     DW'(dbg_ready),        32'd1);
    checkOutput("held_write_we",    DW'(rf_write_enable),  32'd1);
    checkOutput("held_write_waddr", DW'(rf_write_address), 32'd9);
    checkOutput("drain_wb_landed",  cpu_read_value_2,      32'h77);

    // Host write to 3 with a competing pipeline write
    tick();
    applyStimulus(1'b1, 1'b1, 6'd3, 32'hDEAD_BEEF);
    cpu_write_enable = 1'b1; cpu_write_address = 6'd3; cpu_write_value = 32'h1111_1111;
    #1;
    checkOutput("host_w3_we",   DW'(rf_write_enable),  32'd1);
    checkOutput("host_w3_addr", DW'(rf_write_address), 32'd3);
    checkOutput("host_w3_val",  rf_write_value,        32'hDEAD_BEEF);
    tick();
    applyStimulus(1'b1, 1'b0, 6'd3, '0);
    #1;
    checkOutput("host_r3_cpu_blocked", DW'(rf_write_enable),   '0);
    checkOutput("host_r3_raddr1",      DW'(rf_read_address_1), 32'd3);
    checkOutput("host_r3_rvalid_pre",  DW'(dbg_rvalid),        '0);
    tick();
    applyStimulus(1'b0, 1'b0, '0, '0);
    cpu_write_enable = 1'b0;
    #1;
    checkOutput("host_r3_rvalid", DW'(dbg_rvalid), 32'd1);
    checkOutput("host_r3_rdata",  dbg_rdata,       32'hDEAD_BEEF);
    tick();
    checkOutput("host_r3_rvalid_once", DW'(dbg_rvalid), '0);
    checkOutput("host_r3_rdata_hold",  dbg_rdata,       32'hDEAD_BEEF);

    // Register 0 and out-of-range addresses
    applyStimulus(1'b1, 1'b1, 6'd0, 32'hFFFF);
    #1;
    checkOutput("w0_we", DW'(rf_write_enable), '0);
    tick();
    applyStimulus(1'b1, 1'b1, 6'h21, 32'hFFFF);
    #1;
    checkOutput("w21_we", DW'(rf_write_enable), '0);
    tick();
    applyStimulus(1'b1, 1'b0, 6'h21, '0);
    tick();
    applyStimulus(1'b1, 1'b0, 6'd0, '0);
    cpu_read_address_2 = 6'h21;
    #1;
    checkOutput("r21_rvalid",     DW'(dbg_rvalid), 32'd1);
    checkOutput("r21_rdata",      dbg_rdata,       '0);
    checkOutput("r21_not_written", cpu_read_value_2, 32'hA000_0021);
    tick();
    #1;
    checkOutput("r0_rvalid", DW'(dbg_rvalid), 32'd1);
    checkOutput("r0_rdata",  dbg_rdata,       32'hA000_0000);

    // Read accepted in the cycle dbg_halt drops
    applyStimulus(1'b1, 1'b0, 6'd3, '0);
    dbg_halt = 1'b0;
    #1;
    checkOutput("release_ready", DW'(dbg_ready), 32'd1);
    tick();
    applyStimulus(1'b0, 1'b0, '0, '0);
    #1;
    checkOutput("release_hold",   DW'(cpu_hold),   '0);
    checkOutput("release_halted", DW'(dbg_halted), '0);
    checkOutput("release_rvalid", DW'(dbg_rvalid), 32'd1);
    checkOutput("release_rdata",  dbg_rdata,       32'hDEAD_BEEF);
    tick();
    checkOutput("release_rvalid_once", DW'(dbg_rvalid), '0);

    // Reset during DRAIN
    dbg_halt = 1'b1;
    tick();
    checkOutput("drain2_hold", DW'(cpu_hold), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    dbg_halt = 1'b0;
    #1;
    checkOutput("reset_in_drain_hold", DW'(cpu_hold), '0);
    tick();
    checkOutput("reset_in_drain_stays_run", DW'(cpu_hold), '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
